// File: rtl/alu_shift_stage.sv
// alu_shift_stage: one-cycle shift/pass stage with a 2-entry result FIFO.
// The result and its zero/neg flags are computed when a request is accepted
// and stored together, so the output side only reads registered state.
module alu_shift_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic [15:0] op_count
);

  typedef struct packed {
    logic        zero;
    logic        neg;
    logic [31:0] result;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] op_count_q, op_count_d;

  logic        push;
  logic        pop;
  logic        amt_sat;
  logic [4:0]  amt;
  logic [31:0] shift_res;
  entry_t      new_entry;

  // Shift datapath; any set bit in b[31:5] saturates the shift.
  always_comb begin
    amt_sat   = |b[31:5];
    amt       = b[4:0];
    shift_res = a;
    case (op)
      2'b00:   shift_res = amt_sat ? 32'h0 : (a << amt);
      2'b01:   shift_res = amt_sat ? 32'h0 : (a >> amt);
      2'b10:   shift_res = amt_sat ? {32{a[31]}} : $unsigned($signed(a) >>> amt);
      default: shift_res = a;
    endcase
    new_entry.result = shift_res;
    new_entry.zero   = (shift_res == 32'h0);
    new_entry.neg    = shift_res[31];
  end

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign result   = mem_q[rd_ptr_q].result;
  assign zero     = mem_q[rd_ptr_q].zero;
  assign neg      = mem_q[rd_ptr_q].neg;
  assign op_count = op_count_q;

  // FIFO next-state: write at wr_ptr on push, advance rd_ptr and count on pop.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    op_count_d = op_count_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      op_count_d = op_count_q + 16'd1;
    end
  end

  // State registers; reset discards any in-flight entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      op_count_q <= 16'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: doc/alu_shift_stage.md
ALU_SHIFT_STAGE -- requirements
Module: alu_shift_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 The ports SHALL be, clock and reset first:
  - clk  input  1  clock.
  - reset  input  1  synchronous active-high reset.
  - in_valid  input  1  upstream request valid.
  - in_ready  output  1  stage can accept a request.
  - op  input  2  operation select: 00 sll, 01 srl, 10 sra, 11 pass a.
  - a  input  32  operand to shift.
  - b  input  32  shift amount.
  - out_valid  output  1  result valid.
  - out_ready  input  1  downstream accepts result.
  - result  output  32  head-entry result.
  - zero  output  1  head result == 0.
  - neg  output  1  head result bit 31.
  - op_count  output  16  completed-result counter.
REQ-003 The block SHALL have no parameters; widths are fixed as listed.

Function
REQ-004 A request SHALL be accepted in any cycle where in_valid && in_ready; op, a and b are sampled only in that cycle.
REQ-005 The shift amount SHALL be b[4:0] when b[31:5] == 0.
REQ-006 When b[31:5] != 0, the amount SHALL saturate: sll/srl give 32'h00000000, sra gives {32{a[31]}}; pass is unaffected.
REQ-007 sll SHALL zero-fill from the LSB, srl SHALL zero-fill from the MSB, sra SHALL fill with a[31]; an amount of 0 returns a unchanged.
REQ-008 The result, zero and neg SHALL be computed at accept time and stored in a 2-entry FIFO; the flags are stored with the result, not recomputed.
REQ-009 Latency SHALL be 1 cycle: a request accepted in cycle N into an empty FIFO appears with out_valid=1 in cycle N+1.
REQ-010 out_valid SHALL be 1 iff the FIFO count is nonzero; result, zero and neg SHALL show the head entry and are don't-care (held) when out_valid=0.
REQ-011 An entry SHALL be popped when out_valid && out_ready.
REQ-012 While out_valid=1 and out_ready=0, result, zero and neg SHALL remain stable.
REQ-013 in_ready SHALL equal (count < 2), driven from registered state only, with no combinational path from out_ready or in_valid.
REQ-014 Full (count=2): in_ready=0 and no push occurs; a pop in the same cycle still takes effect, and in_ready=1 from the next cycle.
REQ-015 Simultaneous push and pop with count=1 SHALL leave count=1, with the new entry becoming the head in the next cycle.
REQ-016 Empty (count=0) with out_ready=1 SHALL not pop and SHALL not change op_count.
REQ-017 Entries SHALL leave in acceptance order; FIFO pointers are 1 bit and wrap modulo 2.
REQ-018 op_count SHALL increment by 1 on each pop and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-019 When reset=1 at a clock edge, the block SHALL set count=0, out_valid=0, in_ready=1, result=32'h0, zero=0, neg=0, op_count=0, and pointers to 0.
REQ-020 Reset SHALL take priority over a simultaneous accept or pop; in-flight entries are discarded, not drained.
REQ-021 The block SHALL accept a request in the first cycle after reset deasserts.

Verification
REQ-022 Basic latency: accept op=00, a=32'h000008DF, b=5 with out_ready=1 -> next cycle out_valid=1, result=32'h00011BE0, zero=0, neg=0; following cycle out_valid=0, op_count=1.
REQ-023 Shift boundaries:
  - op=00, a=1, b=31 -> 32'h80000000, neg=1.
  - op=10, a=32'h80000000, b=31 -> 32'hFFFFFFFF.
  - op=01, a=32'hFFFFFFFF, b=32 -> 32'h00000000, zero=1.
  - op=10, a=32'h80000000, b=32'h100 -> 32'hFFFFFFFF.
REQ-024 Backpressure: with out_ready=0, accept (sll 1,1) then (sll 2,2) -> in_ready=0; result holds 32'h00000002 for 5+ cycles; raise out_ready -> 32'h00000002 then 32'h00000008; in_ready returns to 1; op_count=2.
REQ-025 Full with simultaneous pop: count=2, in_valid=1, out_ready=1 -> the new request is not accepted that cycle, one entry is popped, and it is accepted the next cycle; order is preserved.
REQ-026 Reset mid-operation: count=2, assert reset for 1 cycle -> out_valid=0, in_ready=1, op_count=0; no stale result appears afterwards.
REQ-027 Counter wrap: preload op_count to 16'hFFFF via 65535 pops, then one more pop -> op_count=16'h0000.
